// File: rtl/cnn_win_sched.sv
// rtl/cnn_win_sched.sv - 3x3 window read scheduler over a raster-filled pixel RAM
// Walks the window anchor (bottom-right pixel) across the frame, issuing 9 tap reads per window.
module cnn_win_sched #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frm_clr,
  input  logic [AW-1:0] wr_cnt,
  input  logic          core_bsy,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic [3:0]    tap_idx,
  output logic          win_strt,
  output logic          frame_done,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ADV, S_DONE} state_t;

  localparam logic [AW-1:0] ANCHOR0 = AW'(2 * IMG_W + 2);
  localparam logic [AW-1:0] COL_MAX = AW'(IMG_W - 3);
  localparam logic [AW-1:0] ROW_MAX = AW'(IMG_H - 3);

  state_t        state_q, state_d;
  logic [AW-1:0] anchor_q, anchor_d;
  logic [AW-1:0] col_q, col_d;
  logic [AW-1:0] row_q, row_d;
  logic [3:0]    tap_q, tap_d;
  logic [AW-1:0] tap_off;
  logic          frame_done_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      anchor_q <= ANCHOR0;
      col_q    <= '0;
      row_q    <= '0;
      tap_q    <= '0;
    end else begin
      state_q  <= state_d;
      anchor_q <= anchor_d;
      col_q    <= col_d;
      row_q    <= row_d;
      tap_q    <= tap_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    anchor_d     = anchor_q;
    col_d        = col_q;
    row_d        = row_q;
    tap_d        = tap_q;
    frame_done_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((anchor_q < wr_cnt) && !core_bsy) begin
          state_d = S_FETCH;
          tap_d   = 4'd0;
        end
      end
      S_FETCH: begin
        if (tap_q == 4'd8) begin
          state_d = S_ADV;
          tap_d   = 4'd0;
        end else begin
          tap_d = tap_q + 4'd1;
        end
      end
      S_ADV: begin
        if ((row_q == ROW_MAX) && (col_q == COL_MAX)) begin
          state_d      = S_DONE;
          frame_done_c = 1'b1;
        end else if (col_q == COL_MAX) begin
          // skip the two left-edge columns of the next row
          state_d  = S_IDLE;
          anchor_d = anchor_q + AW'(3);
          col_d    = '0;
          row_d    = row_q + AW'(1);
        end else begin
          state_d  = S_IDLE;
          anchor_d = anchor_q + AW'(1);
          col_d    = col_q + AW'(1);
        end
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (frm_clr) begin
      state_d      = S_IDLE;
      anchor_d     = ANCHOR0;
      col_d        = '0;
      row_d        = '0;
      tap_d        = '0;
      frame_done_c = 1'b0;
    end
  end

  always_comb begin
    tap_off = '0;
    case (tap_q)
      4'd0:    tap_off = AW'(2 * IMG_W + 2);
      4'd1:    tap_off = AW'(2 * IMG_W + 1);
      4'd2:    tap_off = AW'(2 * IMG_W);
      4'd3:    tap_off = AW'(IMG_W + 2);
      4'd4:    tap_off = AW'(IMG_W + 1);
      4'd5:    tap_off = AW'(IMG_W);
      4'd6:    tap_off = AW'(2);
      4'd7:    tap_off = AW'(1);
      default: tap_off = '0;
    endcase
  end

  assign rd_en      = (state_q == S_FETCH);
  assign rd_addr    = rd_en ? (anchor_q - tap_off) : '0;
  assign tap_idx    = rd_en ? tap_q : 4'd0;
  assign win_strt   = rd_en && (tap_q == 4'd0);
  assign frame_done = frame_done_c;
  assign busy       = (state_q == S_FETCH) || (state_q == S_ADV);

endmodule

// File: tb/tb_cnn_win_sched.sv
// tb/tb_cnn_win_sched.sv - directed self-checking bench for cnn_win_sched
// Default 28x28 frame; expected values are hand-derived from the window geometry.
module tb_cnn_win_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frm_clr;
  logic [9:0] wr_cnt;
  logic       core_bsy;
  logic       rd_en;
  logic [9:0] rd_addr;
  logic [3:0] tap_idx;
  logic       win_strt;
  logic       frame_done;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  cnn_win_sched #(.IMG_W(28), .IMG_H(28), .AW(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frm_clr    (frm_clr),
    .wr_cnt     (wr_cnt),
    .core_bsy   (core_bsy),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .tap_idx    (tap_idx),
    .win_strt   (win_strt),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    frm_clr = 1'b1;
    tick();
    frm_clr = 1'b0;
  endtask

  // advance until win_strt is seen, bounded
  task automatic wait_win(input string tag);
    int n;
    n = 0;
    while (!win_strt && n < 50) begin
      tick();
      n++;
    end
    check(tag, win_strt, 1);
  endtask

  int exp_taps[9] = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
  int first_addr[676];
  int nwin, last_cyc, spacing_err, addr_err, fd_cnt, fd_cyc, last_tap8, mr, mc, seen;

  initial begin
    rst_n    = 1'b0;
    frm_clr  = 1'b0;
    wr_cnt   = 10'd58;
    core_bsy = 1'b0;
    #3;
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_tap_idx", tap_idx, 0);
    check("rst_win_strt", win_strt, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // anchor 58 not yet written
    seen = 0;
    repeat (5) begin
      tick();
      seen |= rd_en;
    end
    check("idle_wr58_rd_en", seen, 0);

    wr_cnt = 10'd59;
    tick();
    check("wr59_fetch", rd_en, 1);
    check("wr59_win_strt", win_strt, 1);
    for (int t = 0; t < 9; t++) begin
      check($sformatf("wr59_addr_t%0d", t), rd_addr, exp_taps[t]);
      check($sformatf("wr59_tap_t%0d", t), tap_idx, t);
      if (t == 1) check("win_strt_only_tap0", win_strt, 0);
      tick();
    end
    check("adv_rd_en", rd_en, 0);
    check("adv_busy", busy, 1);
    check("adv_rd_addr", rd_addr, 0);
    tick();
    tick();
    check("idle_anchor59_busy", busy, 0);
    check("idle_anchor59_rd_en", rd_en, 0);

    // full frame
    wr_cnt = 10'd784;
    pulse_clr();
    nwin = 0; last_cyc = 0; spacing_err = 0; addr_err = 0;
    fd_cnt = 0; fd_cyc = -1; last_tap8 = -1; mr = 0; mc = 0;
    for (int n = 0; n < 8000; n++) begin
      if (win_strt) begin
        if (nwin > 0 && (n - last_cyc) != 11) spacing_err++;
        if (nwin < 676) first_addr[nwin] = int'(rd_addr);
        if (int'(rd_addr) != mr * 28 + mc) addr_err++;
        if (mc == 25) begin mc = 0; mr++; end else mc++;
        last_cyc = n;
        nwin++;
      end
      if (rd_en && tap_idx == 4'd8) last_tap8 = int'(rd_addr);
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = n;
        break;
      end
      tick();
    end
    check("frame_win_count", nwin, 676);
    check("frame_spacing_err", spacing_err, 0);
    check("frame_addr_err", addr_err, 0);
    check("frame_first_addr_w0", first_addr[0], 0);
    check("frame_first_addr_w25", first_addr[25], 25);
    check("frame_first_addr_w26", first_addr[26], 28);
    check("frame_last_tap8_addr", last_tap8, 783);
    check("frame_done_seen", fd_cnt, 1);
    check("frame_done_timing", fd_cyc - last_cyc, 9);
    tick();
    check("frame_done_pulse", frame_done, 0);

    // DONE ignores wr_cnt and core_bsy
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      wr_cnt   = 10'($urandom_range(0, 1023));
      core_bsy = i[0];
      tick();
      seen |= rd_en | busy | frame_done;
    end
    check("done_quiet", seen, 0);

    // restart with core busy held off
    wr_cnt   = 10'd784;
    core_bsy = 1'b1;
    pulse_clr();
    seen = 0;
    repeat (5) begin
      tick();
      seen |= rd_en;
    end
    check("bsy_idle_no_rd", seen, 0);
    core_bsy = 1'b0;
    tick();
    check("restart_win_strt", win_strt, 1);
    check("restart_addr0", rd_addr, 0);
    tick();
    tick();
    core_bsy = 1'b1;
    seen = 2;
    for (int i = 0; i < 12; i++) begin
      if (rd_en) begin
        seen++;
        if (tap_idx == 4'd8) check("bsy_mid_tap8_addr", rd_addr, 58);
      end
      tick();
    end
    check("bsy_mid_tap_count", seen, 9);
    check("bsy_held_idle", rd_en, 0);

    // frm_clr at tap 4 of window 1 (anchor 59)
    core_bsy = 1'b0;
    wait_win("clr_wait_win");
    check("clr_win_addr", rd_addr, 1);
    repeat (4) tick();
    check("clr_at_tap4", tap_idx, 4);
    pulse_clr();
    check("clr_rd_en_low", rd_en, 0);
    check("clr_no_frame_done", frame_done, 0);
    tick();
    check("clr_restart_strt", win_strt, 1);
    check("clr_restart_addr", rd_addr, 0);

    // async reset mid-FETCH
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_fetch_rd_en", rd_en, 0);
    check("rst_mid_fetch_busy", busy, 0);
    wr_cnt = 10'd58;
    tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      tick();
      seen |= rd_en;
    end
    check("rst_abort_no_rd", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_win_sched.md
CNN_WIN_SCHED -- requirements
Module: cnn_win_sched

Interface
REQ-001 SHALL have parameter IMG_W, default 28, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 28, image height in pixels.
REQ-003 SHALL have parameter AW, default 10, pixel-RAM address width; IMG_W*IMG_H <= 2**AW.
REQ-004 SHALL have port clk  input  1  clock, rising-edge active.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port frm_clr  input  1  single-cycle pulse that abandons the current frame and restarts scheduling.
REQ-007 SHALL have port wr_cnt  input  AW  count of pixels already written to the pixel RAM, raster order.
REQ-008 SHALL have port core_bsy  input  1  convolution core busy; no new window may start while high.
REQ-009 SHALL have port rd_en  output  1  pixel-RAM read strobe.
REQ-010 SHALL have port rd_addr  output  AW  pixel-RAM read address, valid when rd_en=1.
REQ-011 SHALL have port tap_idx  output  4  tap number 0..8 of the current read.
REQ-012 SHALL have port win_strt  output  1  pulse, high with tap 0 of each window.
REQ-013 SHALL have port frame_done  output  1  pulse after the last window of the frame.
REQ-014 SHALL have port busy  output  1  high in FETCH and ADV.

Function
REQ-015 SHALL hold internal anchor (AW bits; bottom-right pixel of the 3x3 window), col (0..IMG_W-3) and row (0..IMG_H-3).
REQ-016 SHALL implement states IDLE, FETCH, ADV, DONE.
REQ-017 IDLE -> FETCH SHALL occur when anchor < wr_cnt and core_bsy=0; otherwise SHALL stay in IDLE.
REQ-018 FETCH SHALL last exactly 9 cycles, with rd_en=1 and tap_idx=0..8 in consecutive cycles.
REQ-019 In FETCH, rd_addr SHALL be anchor minus, per tap 0..8: 2W+2, 2W+1, 2W, W+2, W+1, W, 2, 1, 0 (W=IMG_W), in modulo-2**AW arithmetic.
REQ-020 win_strt SHALL be high only in the tap-0 cycle.
REQ-021 core_bsy SHALL be ignored once FETCH has started; the 9 taps SHALL not stall.
REQ-022 After tap 8, the block SHALL enter ADV for one cycle with rd_en=0.
REQ-023 In ADV, when col < IMG_W-3: anchor SHALL increase by 1 and col by 1.
REQ-024 In ADV, when col = IMG_W-3: anchor SHALL increase by 3, col SHALL return to 0 and row SHALL increase by 1 (row wrap).
REQ-025 In ADV, when row = IMG_H-3 and col = IMG_W-3: the block SHALL pulse frame_done for one cycle, leave anchor, col and row unchanged, and enter DONE; otherwise ADV -> IDLE.
REQ-026 DONE SHALL hold rd_en=0 and ignore wr_cnt and core_bsy until frm_clr.
REQ-027 frm_clr SHALL take priority in every state: next cycle state=IDLE, anchor=2*IMG_W+2, col=0, row=0, rd_en=0, with no frame_done pulse.
REQ-028 A frame SHALL yield exactly (IMG_W-2)*(IMG_H-2) windows, 676 at default parameters.
REQ-029 The minimum window period SHALL be 11 cycles: IDLE, FETCH x9, ADV.
REQ-030 When rd_en=0, rd_addr and tap_idx SHALL be 0.

Reset
REQ-031 On rst_n=0, the block SHALL immediately set state=IDLE, anchor=2*IMG_W+2 (58 at default), col=0, row=0, rd_en=0, rd_addr=0, tap_idx=0, win_strt=0, frame_done=0, busy=0.
REQ-032 Reset asserted during FETCH SHALL abort the window with no further rd_en.

Verification
REQ-033 Reset release with wr_cnt=58 -> block stays IDLE with rd_en=0; wr_cnt=59 -> FETCH next cycle with rd_addr 0,1,2,28,29,30,56,57,58.
REQ-034 wr_cnt=784, core_bsy=0 -> 676 win_strt pulses spaced 11 cycles apart, then one frame_done; last window rd_addr ends at 783.
REQ-035 Window with col=25 (anchor=83) -> next anchor 86 and col=0; first tap of next window reads 28.
REQ-036 core_bsy=1 in IDLE with data available -> no rd_en; core_bsy=1 raised mid-FETCH -> all 9 taps still issued.
REQ-037 frm_clr at tap 4 -> rd_en low next cycle; after clr with wr_cnt=784, first window again starts at rd_addr 0.
REQ-038 In DONE with wr_cnt changing -> no rd_en until frm_clr; then scheduling restarts at anchor=58.
